// File: rtl/jt053246_draw_pkg.sv
// Shared types and constants for the 053246 sprite tile-row draw engine.
package jt053246_draw_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned ATTR_W = 10;
  localparam int unsigned SHD_W  = 2;
  localparam int unsigned YSUB_W = 4;
  localparam int unsigned HPOS_W = 9;
  localparam int unsigned ZOOM_W = 10;
  localparam int unsigned ROM_AW = 21;
  localparam int unsigned ROM_DW = 32;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned NPIX   = 16;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned BUF_DW = 16;
  localparam int unsigned ACC_W  = 11;

  localparam logic [ZOOM_W-1:0] ZOOM_ONE = 10'h40;
  localparam logic [ZOOM_W-1:0] ZOOM_MIN = 10'h8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    DRAW   = 2'd3
  } state_e;

  typedef struct packed {
    logic [SHD_W-1:0]  shd;
    logic [ATTR_W-1:0] attr;
    logic [PIX_W-1:0]  pix;
  } buf_data_t;

  // Very small steps would stretch a tile past any useful width.
  function automatic logic [ZOOM_W-1:0] zoom_eff(input logic [ZOOM_W-1:0] hz);
    return (hz < ZOOM_MIN) ? ZOOM_MIN : hz;
  endfunction

endpackage

// File: rtl/jt053246_draw_if.sv
// Scanner, object ROM and line-buffer signals of the draw engine.
interface jt053246_draw_if
  import jt053246_draw_pkg::*;
#(
  parameter int unsigned AW = 9
);
  logic                start;
  logic [CODE_W-1:0]   code;
  logic [ATTR_W-1:0]   attr;
  logic [SHD_W-1:0]    shd;
  logic                hflip;
  logic                vflip;
  logic [YSUB_W-1:0]   ysub;
  logic [HPOS_W-1:0]   hpos;
  logic [ZOOM_W-1:0]   hzoom;
  logic                hz_keep;
  logic                busy;
  logic [ROM_AW-1:0]   rom_addr;
  logic                rom_cs;
  logic                rom_ok;
  logic [ROM_DW-1:0]   rom_data;
  logic [AW-1:0]       buf_addr;
  logic [BUF_DW-1:0]   buf_data;
  logic                buf_we;

  modport master (
    output start, code, attr, shd, hflip, vflip, ysub, hpos, hzoom, hz_keep,
    output rom_ok, rom_data,
    input  busy, rom_addr, rom_cs, buf_addr, buf_data, buf_we
  );

  modport slave (
    input  start, code, attr, shd, hflip, vflip, ysub, hpos, hzoom, hz_keep,
    input  rom_ok, rom_data,
    output busy, rom_addr, rom_cs, buf_addr, buf_data, buf_we
  );
endinterface

// File: rtl/jt053246_draw_zoom.sv
// Horizontal zoom phase accumulator, output position and end-of-tile detection.
// JT053246_DRAW_ZOOM_EN enables variable zoom and cross-tile phase continuation.
module jt053246_draw_zoom
  import jt053246_draw_pkg::*;
#(
  parameter int unsigned AW    = 9,
  parameter int unsigned MAXPX = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              load,
  input  logic              keep,
  input  logic [AW-1:0]     hpos,
  input  logic [ZOOM_W-1:0] hzoom,
  input  logic              step,
  output logic [SRC_W-1:0]  src_idx,
  output logic [AW-1:0]     pos,
  output logic              end_c
);
  localparam int unsigned CNT_W = $clog2(MAXPX + 1);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_next_c;
  logic [AW-1:0]     pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ZOOM_W-1:0] zeff_c;
  logic              ovf_c, cap_c;

`ifdef JT053246_DRAW_ZOOM_EN
  logic [ZOOM_W-1:0] hzoom_q, hzoom_d;
  logic [ZOOM_W-1:0] res_q, res_d;
  logic [AW-1:0]     npos_q, npos_d;
`else
  logic              unused_c;
  assign unused_c = ^{hzoom, keep};
`endif

  always_comb begin
    acc_d  = acc_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
`ifdef JT053246_DRAW_ZOOM_EN
    hzoom_d = hzoom_q;
    res_d   = res_q;
    npos_d  = npos_q;
    zeff_c  = zoom_eff(hzoom_q);
`else
    zeff_c  = ZOOM_ONE;
`endif
    acc_next_c = acc_q + ACC_W'(zeff_c);
    ovf_c      = acc_next_c[ACC_W-1];
    cap_c      = (cnt_q == CNT_W'(MAXPX - 1));
    end_c      = ovf_c | cap_c;

    if (load) begin
      cnt_d = '0;
`ifdef JT053246_DRAW_ZOOM_EN
      hzoom_d = hzoom;
      if (keep) begin
        acc_d = {1'b0, res_q};
        pos_d = npos_q;
      end else begin
        acc_d = '0;
        pos_d = hpos;
      end
`else
      acc_d = '0;
      pos_d = hpos;
`endif
    end else if (step) begin
      acc_d = acc_next_c;
      pos_d = pos_q + AW'(1);
      cnt_d = cnt_q + CNT_W'(1);
`ifdef JT053246_DRAW_ZOOM_EN
      // A tile cut short by the pixel cap leaves no usable phase.
      if (end_c) begin
        res_d  = ovf_c ? acc_next_c[ZOOM_W-1:0] : '0;
        npos_d = pos_q + AW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
`ifdef JT053246_DRAW_ZOOM_EN
      hzoom_q <= '0;
      res_q   <= '0;
      npos_q  <= '0;
`endif
    end else if (cen) begin
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
`ifdef JT053246_DRAW_ZOOM_EN
      hzoom_q <= hzoom_d;
      res_q   <= res_d;
      npos_q  <= npos_d;
`endif
    end
  end

  assign src_idx = acc_q[ZOOM_W-1:ZOOM_W-SRC_W];
  assign pos     = pos_q;

endmodule

// File: rtl/jt053246_draw.sv
// 053246 sprite draw engine: fetches one 16-pixel tile row and writes it to the line buffer.
// Build with JT053246_DRAW_ZOOM_EN for horizontal zoom support.
module jt053246_draw
  import jt053246_draw_pkg::*;
#(
  parameter int unsigned AW    = 9,
  parameter int unsigned MAXPX = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  jt053246_draw_if.slave bus
);
  state_e                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       rom_cs_q, rom_cs_d;
  logic                       guard_q, guard_d;
  logic                       hflip_q, hflip_d;
  logic                       buf_we_q, buf_we_d;
  logic [ROM_AW-1:0]          rom_addr_q, rom_addr_d;
  logic [NPIX-1:0][PIX_W-1:0] pix_q, pix_d;
  logic [ATTR_W-1:0]          attr_q, attr_d;
  logic [SHD_W-1:0]           shd_q, shd_d;
  logic [AW-1:0]              buf_addr_q, buf_addr_d;
  buf_data_t                  buf_data_q, buf_data_d;

  logic                       load_c, step_c, end_c, ok_c;
  logic [SRC_W-1:0]           src_idx, src_c;
  logic [PIX_W-1:0]           pix_c;
  logic [AW-1:0]              pos;

  assign load_c = (state_q == IDLE) & bus.start;
  assign step_c = (state_q == DRAW);
  // The ROM may still present the previous request's ok right after an address change.
  assign ok_c   = bus.rom_ok & ~guard_q;
  assign src_c  = src_idx ^ {SRC_W{hflip_q}};
  assign pix_c  = pix_q[src_c];

  jt053246_draw_zoom #(
    .AW    (AW),
    .MAXPX (MAXPX)
  ) u_zoom (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .load    (load_c),
    .keep    (bus.hz_keep),
    .hpos    (AW'(bus.hpos)),
    .hzoom   (bus.hzoom),
    .step    (step_c),
    .src_idx (src_idx),
    .pos     (pos),
    .end_c   (end_c)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rom_cs_d   = rom_cs_q;
    guard_d    = 1'b0;
    hflip_d    = hflip_q;
    buf_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    pix_d      = pix_q;
    attr_d     = attr_q;
    shd_d      = shd_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          attr_d     = bus.attr;
          shd_d      = bus.shd;
          hflip_d    = bus.hflip;
          rom_addr_d = {bus.code, bus.ysub ^ {YSUB_W{bus.vflip}}, 1'b0};
          rom_cs_d   = 1'b1;
          busy_d     = 1'b1;
          guard_d    = 1'b1;
          state_d    = FETCH0;
        end
      end
      FETCH0: begin
        if (ok_c) begin
          for (int i = 0; i < 8; i++) begin
            pix_d[i] = bus.rom_data[(7 - i) * PIX_W +: PIX_W];
          end
          rom_addr_d[0] = 1'b1;
          guard_d       = 1'b1;
          state_d       = FETCH1;
        end
      end
      FETCH1: begin
        if (ok_c) begin
          for (int i = 0; i < 8; i++) begin
            pix_d[8 + i] = bus.rom_data[(7 - i) * PIX_W +: PIX_W];
          end
          rom_cs_d = 1'b0;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        buf_we_d   = (pix_c != '0);
        buf_addr_d = pos;
        buf_data_d = '{shd: shd_q, attr: attr_q, pix: pix_c};
        if (end_c) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rom_cs_q   <= 1'b0;
      guard_q    <= 1'b0;
      hflip_q    <= 1'b0;
      buf_we_q   <= 1'b0;
      rom_addr_q <= '0;
      pix_q      <= '0;
      attr_q     <= '0;
      shd_q      <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else if (cen) begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rom_cs_q   <= rom_cs_d;
      guard_q    <= guard_d;
      hflip_q    <= hflip_d;
      buf_we_q   <= buf_we_d;
      rom_addr_q <= rom_addr_d;
      pix_q      <= pix_d;
      attr_q     <= attr_d;
      shd_q      <= shd_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.buf_we   = buf_we_q;
  assign bus.buf_addr = buf_addr_q;
  assign bus.buf_data = BUF_DW'(buf_data_q);

endmodule
